// File: rtl/ring_pkg.sv
// Shared ring constants used by both the store (write) side and the retrieve side.
package ring_pkg;

  localparam int RING_PTR_W_DEFAULT = 2;
  localparam int RING_OVF_CNT_W     = 8;

endpackage

// File: rtl/ring_ptr_cmp.sv
// Pointer comparator: derives full/empty/level from wrap-bit write and read pointers.
module ring_ptr_cmp
  import ring_pkg::*;
#(
  parameter int COUNTER_SIZE = RING_PTR_W_DEFAULT
) (
  input  logic [COUNTER_SIZE:0] wrptr,
  input  logic [COUNTER_SIZE:0] rdptr,
  output logic                  full,
  output logic                  empty,
  output logic [COUNTER_SIZE:0] level
);

  // Same index with opposite wrap bits means the writer is exactly one lap ahead.
  assign full  = (wrptr[COUNTER_SIZE] != rdptr[COUNTER_SIZE]) &&
                 (wrptr[COUNTER_SIZE-1:0] == rdptr[COUNTER_SIZE-1:0]);
  assign empty = (wrptr == rdptr);
  assign level = wrptr - rdptr;

endmodule

// File: rtl/ring_store.sv
// Write side of a 1-bit ring buffer with sticky overflow status.
// Optional saturating drop counter ovf_cnt enabled by macro RING_STORE_OVF_CNT_EN.
module ring_store
  import ring_pkg::*;
#(
  parameter int COUNTER_SIZE = RING_PTR_W_DEFAULT,
  parameter int BUFFER_SIZE  = 2 ** COUNTER_SIZE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    instrobe,
  input  logic                    txda,
  input  logic [COUNTER_SIZE:0]   rdptr,
  input  logic                    ovf_clr,
  output logic [COUNTER_SIZE:0]   wrptr,
  output logic [BUFFER_SIZE-1:0]  buffer,
  output logic                    full,
  output logic                    empty,
  output logic [COUNTER_SIZE:0]   level,
  output logic                    ovf
`ifdef RING_STORE_OVF_CNT_EN
  ,
  output logic [RING_OVF_CNT_W-1:0] ovf_cnt
`endif
);

  localparam logic [COUNTER_SIZE:0] PTR_ONE = 1;

  logic do_write;
  logic drop;

  ring_ptr_cmp #(
    .COUNTER_SIZE (COUNTER_SIZE)
  ) u_cmp (
    .wrptr (wrptr),
    .rdptr (rdptr),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // full is the pre-edge value, so a read advance in the same cycle cannot rescue a write.
  assign do_write = instrobe && !full;
  assign drop     = instrobe &&  full;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the storage cells are reset because they are a visible output, not hidden RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrptr  <= '0;
      buffer <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_write) begin
        buffer[wrptr[COUNTER_SIZE-1:0]] <= txda;
        wrptr                           <= wrptr + PTR_ONE;
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef RING_STORE_OVF_CNT_EN
  localparam logic [RING_OVF_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RING_OVF_CNT_W-1:0] CNT_ONE = 1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= drop ? CNT_ONE : '0;
    end else if (drop && (ovf_cnt != CNT_MAX)) begin
      ovf_cnt <= ovf_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_ring_store.sv
// Self-checking bench for ring_store (COUNTER_SIZE=2): directed cases plus randomized traffic
// against a counting model. Define RING_STORE_OVF_CNT_EN to also exercise ovf_cnt.
module tb_ring_store;

  localparam int CS   = 2;
  localparam int BUF  = 4;
  localparam int PMOD = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           instrobe;
  logic           txda;
  logic [CS:0]    rdptr;
  logic           ovf_clr;
  logic [CS:0]    wrptr;
  logic [BUF-1:0] buffer;
  logic           full;
  logic           empty;
  logic [CS:0]    level;
  logic           ovf;
`ifdef RING_STORE_OVF_CNT_EN
  logic [7:0]     ovf_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Model: total write count and read position as plain integers modulo 8, cells as a bit array.
  int m_wr;
  int m_rd;
  bit m_mem [BUF];
  bit m_ovf;
  int m_cnt;

  ring_store #(
    .COUNTER_SIZE (CS),
    .BUFFER_SIZE  (BUF)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .instrobe (instrobe),
    .txda     (txda),
    .rdptr    (rdptr),
    .ovf_clr  (ovf_clr),
    .wrptr    (wrptr),
    .buffer   (buffer),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .ovf      (ovf)
`ifdef RING_STORE_OVF_CNT_EN
    ,
    .ovf_cnt  (ovf_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int m_level();
    return ((m_wr - m_rd) % PMOD + PMOD) % PMOD;
  endfunction

  function automatic logic [BUF-1:0] m_buffer();
    logic [BUF-1:0] b;
    for (int i = 0; i < BUF; i++) b[i] = m_mem[i];
    return b;
  endfunction

  task automatic model_reset();
    m_wr  = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < BUF; i++) m_mem[i] = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".buffer"}, 32'(buffer), 32'(m_buffer()));
    check({tag, ".wrptr"},  32'(wrptr),  32'(m_wr));
    check({tag, ".level"},  32'(level),  32'(m_level()));
    check({tag, ".full"},   32'(full),   32'(m_level() == BUF));
    check({tag, ".empty"},  32'(empty),  32'(m_level() == 0));
    check({tag, ".ovf"},    32'(ovf),    32'(m_ovf));
`ifdef RING_STORE_OVF_CNT_EN
    check({tag, ".ovf_cnt"}, 32'(ovf_cnt), 32'(m_cnt));
`endif
  endtask

  // Inputs are stable around the edge; the model evaluates fullness from pre-edge values.
  task automatic tick(input string tag);
    bit was_full;
    @(posedge clock);
    was_full = (m_level() == BUF);
    if (reset) begin
      if (instrobe && was_full) begin
        m_ovf = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end else if (instrobe) begin
        m_mem[m_wr % BUF] = txda;
        m_wr = (m_wr + 1) % PMOD;
      end
      if (ovf_clr && !(instrobe && was_full)) m_ovf = 1'b0;
      if (ovf_clr) m_cnt = (instrobe && was_full) ? 1 : 0;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit s, input bit d, input bit c);
    instrobe = s;
    txda     = d;
    ovf_clr  = c;
  endtask

  task automatic set_rd(input int rd);
    m_rd  = rd % PMOD;
    rdptr = 3'(m_rd);
    #1;
  endtask

  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    rdptr = '0;
    m_rd  = 0;
    model_reset();

    // Reset state held across clock edges
    tick("rst0");
    tick("rst1");
    #2 reset = 1'b1;

    // Four consecutive writes 1,0,1,1 fill the ring
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, pat[i], 1'b0);
      tick("fill");
    end
    check("fill.buffer_const", 32'(buffer), 32'b1101);
    check("fill.wrptr_const",  32'(wrptr),  32'b100);
    check("fill.full_const",   32'(full),   32'd1);
    check("fill.level_const",  32'(level),  32'd4);

    // Write while full is dropped, ovf set, then cleared
    drive(1'b1, 1'b0, 1'b0);
    tick("drop");
    check("drop.ovf_const", 32'(ovf), 32'd1);
    drive(1'b0, 1'b0, 1'b1);
    tick("clr");
    check("clr.ovf_const", 32'(ovf), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    tick("idle");

    // Reader frees two cells; three strobes write cells 0,1 then drop
    set_rd(3'b010);
    check_all("rd2");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick("wrap");
    end
    check("wrap.wrptr_const",  32'(wrptr),  32'b110);
    check("wrap.buffer_const", 32'(buffer), 32'b1111);
    check("wrap.full_const",   32'(full),   32'd1);
    check("wrap.ovf_const",    32'(ovf),    32'd1);

    // Clear, then overflow and clear together: overflow wins
    drive(1'b0, 1'b0, 1'b1);
    tick("clr2");
    drive(1'b1, 1'b0, 1'b1);
    tick("ovf_vs_clr");
    check("ovf_vs_clr.ovf_const", 32'(ovf), 32'd1);
`ifdef RING_STORE_OVF_CNT_EN
    check("ovf_vs_clr.cnt_const", 32'(ovf_cnt), 32'd1);
`endif

    // Read pointer advance on the same edge as a write while full: write dropped
    drive(1'b1, 1'b0, 1'b0);
    tick("adv_same_edge");
    set_rd(3'b011);
    check_all("adv_after");

    // Randomized traffic with a reader that consumes up to the current level
    for (int n = 0; n < 250; n++) begin
      drive(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 9) == 0));
      tick("rand");
      set_rd(m_rd + $urandom_range(0, m_level()));
      check_all("rand_rd");
    end

    // Reset asserted between edges during a burst: immediate, and the strobe is lost
    drive(1'b1, 1'b1, 1'b0);
    #2 reset = 1'b0;
    set_rd(0);
    model_reset();
    check_all("midrst");
    tick("midrst_edge");
    #2 reset = 1'b1;

    // First edge after reset is functional
    drive(1'b1, 1'b1, 1'b0);
    tick("post_rst");
    check("post_rst.buffer_const", 32'(buffer), 32'b0001);
    check("post_rst.wrptr_const",  32'(wrptr),  32'b001);
    drive(1'b0, 1'b0, 1'b0);

`ifdef RING_STORE_OVF_CNT_EN
    // Drop counter saturates at 255
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick("cnt_fill");
    end
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick("cnt_sat");
    end
    check("cnt_sat.const", 32'(ovf_cnt), 32'd255);
    drive(1'b0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
